adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arb_pkg.sv | 22 ++
 rtl/adder_arbiter_if.sv | 34 +++
 rtl/Adder_16bit.sv | 15 +
 rtl/adder_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
package adder_arb_pkg;

    // Operand width of the shared adder datapath.
    localparam int unsigned ADD_WIDTH = 16;

    // Default number of requesters sharing the adder.
    localparam int unsigned NUM_REQ_DEFAULT = 4;

    // Arbiter control states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StResp = 2'd2
    } state_e;

    // Increment an index modulo n (used for the round-robin pointer).
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bus between the requesters, the consumer and the adder arbiter.
interface adder_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned WIDTH   = ADD_WIDTH
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_x;
    logic [NUM_REQ*WIDTH-1:0] req_y;
    logic [NUM_REQ-1:0]       req_cin;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_carry;
    logic                     busy;

    // Requester/consumer side.
    modport master (
        output req_valid, req_x, req_y, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_x, req_y, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
    );

endinterface

// File: rtl/Adder_16bit.sv
// 16-bit ripple-style adder with carry-in and carry-out; the shared datapath.
module Adder_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    // Unsigned 17-bit sum of both operands and the carry-in.
    always_comb begin
        {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {16'd0, cin_i};
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter granting one requester at a time access to a single shared adder.
// Grant in IDLE, registered add in ADD, result held in RESP until the consumer takes it.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned WIDTH   = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_arbiter_if.slave   bus
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic                 cin_q, cin_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 carry_q, carry_d;

    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]   req_ready;

    // First valid index at or after 'start', wrapping; MSB of the result flags a hit.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    start);
        logic [ID_W:0] res;
        int            j;
        res = '0;
        // Walk from the farthest candidate back so the closest valid one wins.
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            j = (int'(start) + i) % int'(NUM_REQ);
            if (valid[j]) begin
                res = {1'b1, ID_W'(j)};
            end
        end
        return res;
    endfunction

    // The one and only adder in the datapath, fed from the captured operands.
    Adder_16bit u_adder (
        .a_i    (x_q),
        .b_i    (y_q),
        .cin_i  (cin_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Round-robin selection from current requests and pointer.
    always_comb begin
        {grant_found, grant_idx} = rr_pick(bus.req_valid, ptr_q);
    end

    // Next-state, capture and handshake logic.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        x_d           = x_q;
        y_d           = y_q;
        cin_d         = cin_q;
        sum_d         = sum_q;
        carry_d       = carry_q;
        req_ready     = '0;
        bus.rsp_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gate with rst_n so no grant is shown while reset is held.
                if (grant_found && rst_n) begin
                    req_ready[grant_idx] = 1'b1;
                    id_d    = grant_idx;
                    x_d     = bus.req_x[int'(grant_idx)*int'(WIDTH) +: WIDTH];
                    y_d     = bus.req_y[int'(grant_idx)*int'(WIDTH) +: WIDTH];
                    cin_d   = bus.req_cin[grant_idx];
                    ptr_d   = ID_W'(wrap_inc(int'(grant_idx), NUM_REQ));
                    state_d = StAdd;
                end
            end
            StAdd: begin
                sum_d   = add_sum;
                carry_d = add_cout;
                state_d = StResp;
            end
            StResp: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, pointer, operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Registered results straight to the bus.
    always_comb begin
        bus.req_ready = req_ready;
        bus.rsp_id    = id_q;
        bus.rsp_sum   = sum_q;
        bus.rsp_carry = carry_q;
        bus.busy      = (state_q != StIdle);
    end

endmodule
